// File: rtl/alu_ser_pkg.sv
// rtl/alu_ser_pkg.sv - shared state enum and default constants for the ALU result serializer (ALU_SER_PARITY_EN adds PARITY)
package alu_ser_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef ALU_SER_PARITY_EN
        , PARITY = 2'd2
`endif
    } ser_state_e;

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - loadable down-counter with zero flag that paces the data bits of a frame
module ser_bit_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_value_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - parallel-to-serial frame transmitter; ALU_SER_PARITY_EN appends an even-parity bit
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdata,
    output logic             sframe,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
`ifdef ALU_SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    ser_bit_counter #(.CW(CW)) u_bit_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (cnt_load),
        .load_value_i (CW'(WIDTH - 1)),
        .dec_i        (cnt_dec),
        .zero_o       (cnt_zero)
    );

    assign load_ready = (state_q == IDLE);

    // The shift register always holds the bits still to be sent, next one at the outgoing end.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef ALU_SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d  = SHIFT;
                    cnt_load = 1'b1;
                    sframe_d = 1'b1;
                    sdata_d  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
                    shift_d  = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
`ifdef ALU_SER_PARITY_EN
                    parity_d = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (cnt_zero) begin
`ifdef ALU_SER_PARITY_EN
                    state_d  = PARITY;
                    sframe_d = 1'b1;
                    sdata_d  = parity_q;
`else
                    state_d  = IDLE;
                    done_d   = 1'b1;
`endif
                end else begin
                    cnt_dec  = 1'b1;
                    sframe_d = 1'b1;
                    sdata_d  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
                    shift_d  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                end
            end
`ifdef ALU_SER_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
        end
    end

`ifdef ALU_SER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign sdata  = sdata_q;
    assign sframe = sframe_q;
    assign done   = done_q;

endmodule
